// File: rtl/tmr_pkg.sv
// Shared definitions for the triple-modular-redundancy voter and its monitor.
// Holds the default counter width, the index-width helper and the saturating
// increment used by every mismatch counter.
package tmr_pkg;

  localparam int CNT_WIDTH_DEFAULT = 16;

  // Width needed to address a bit inside a WIDTH-bit word, never below one.
  function automatic int idxWidth(input int w);
    int r;
    r = $clog2(w);
    return (r < 1) ? 1 : r;
  endfunction

  // Adds one unless the value already holds the largest number that fits in
  // 'width' bits, so counters stick at all-ones instead of wrapping.
  // Counters up to 64 bits wide are supported.
  function automatic logic [63:0] satInc(input logic [63:0] val, input int width);
    logic [63:0] maxVal;
    maxVal = {64{1'b1}} >> (64 - width);
    return (val == maxVal) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/majority_voter_monitor_if.sv
// Bus bundle for majority_voter_monitor: three replicas and a clear request
// going in, the voted word and error bookkeeping coming out.
// Optional macro MAJORITY_VOTER_LANE_CNT_EN adds the per-replica counters.
// WIDTH and CNT_WIDTH must match the parameters of the attached voter.
interface majority_voter_monitor_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = tmr_pkg::CNT_WIDTH_DEFAULT
);
  localparam int IDX_W = tmr_pkg::idxWidth(WIDTH);

  logic [WIDTH-1:0]     inA;
  logic [WIDTH-1:0]     inB;
  logic [WIDTH-1:0]     inC;
  logic                 clr;
  logic [WIDTH-1:0]     out;
  logic                 tmrErr;
  logic                 errSticky;
  logic [IDX_W-1:0]     errIdx;
  logic [CNT_WIDTH-1:0] errCnt;
`ifdef MAJORITY_VOTER_LANE_CNT_EN
  logic [CNT_WIDTH-1:0] errCntA;
  logic [CNT_WIDTH-1:0] errCntB;
  logic [CNT_WIDTH-1:0] errCntC;

  modport master (
    output inA, inB, inC, clr,
    input  out, tmrErr, errSticky, errIdx, errCnt, errCntA, errCntB, errCntC
  );

  modport slave (
    input  inA, inB, inC, clr,
    output out, tmrErr, errSticky, errIdx, errCnt, errCntA, errCntB, errCntC
  );
`else
  modport master (
    output inA, inB, inC, clr,
    input  out, tmrErr, errSticky, errIdx, errCnt
  );

  modport slave (
    input  inA, inB, inC, clr,
    output out, tmrErr, errSticky, errIdx, errCnt
  );
`endif

endinterface

// File: rtl/tmr_vote_bit.sv
// One-bit two-out-of-three voter; also reports whether the three copies
// disagree at all.
module tmr_vote_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic vote_o,
  output logic mis_o
);

  // Majority of three plus a flag for any disagreement among the copies.
  always_comb begin
    vote_o = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
    mis_o  = ~((a_i == b_i) && (b_i == c_i));
  end

endmodule

// File: rtl/majority_voter_monitor.sv
// Registered TMR voter with upset bookkeeping: votes three replicas bitwise,
// flags disagreement, counts mismatch cycles with saturation and keeps the
// lowest mismatching bit index of the first upset since the last clear.
// Optional macro MAJORITY_VOTER_LANE_CNT_EN adds per-replica counters that
// track which copy disagreed with the vote.
module majority_voter_monitor
  import tmr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input logic                     clk,
  input logic                     rst,
  majority_voter_monitor_if.slave bus
);

  localparam int IDX_W = idxWidth(WIDTH);

  logic [WIDTH-1:0]     vote;
  logic [WIDTH-1:0]     mis;
  logic                 anyMis;
  logic [IDX_W-1:0]     lowIdx;

  logic [WIDTH-1:0]     out_q, out_d;
  logic                 tmrErr_q, tmrErr_d;
  logic                 errSticky_q, errSticky_d;
  logic [IDX_W-1:0]     errIdx_q, errIdx_d;
  logic [CNT_WIDTH-1:0] errCnt_q, errCnt_d;

  // A clear restarts the count at this cycle's mismatch; otherwise a mismatch
  // bumps the count unless it is already pinned at all-ones.
  function automatic logic [CNT_WIDTH-1:0] cntNext(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 clear,
    input logic                 inc
  );
    if (clear)
      return inc ? CNT_WIDTH'(1) : '0;
    else if (inc)
      return CNT_WIDTH'(satInc(64'(cur), CNT_WIDTH));
    else
      return cur;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      tmr_vote_bit u_vote (
        .a_i    (bus.inA[gi]),
        .b_i    (bus.inB[gi]),
        .c_i    (bus.inC[gi]),
        .vote_o (vote[gi]),
        .mis_o  (mis[gi])
      );
    end
  endgenerate

  assign anyMis = |mis;

  // Priority encoder: scanning from the top down leaves the lowest set bit.
  always_comb begin
    lowIdx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mis[i]) lowIdx = IDX_W'(i);
    end
  end

  // Next state for the voted word, the error pulse, the counter and the
  // first-upset capture; a clear in a mismatch cycle records that cycle.
  always_comb begin
    out_d       = vote;
    tmrErr_d    = anyMis;
    errCnt_d    = cntNext(errCnt_q, bus.clr, anyMis);
    errSticky_d = errSticky_q;
    errIdx_d    = errIdx_q;
    if (bus.clr) begin
      errSticky_d = anyMis;
      errIdx_d    = anyMis ? lowIdx : '0;
    end else if (anyMis && !errSticky_q) begin
      errSticky_d = 1'b1;
      errIdx_d    = lowIdx;
    end
  end

  // State registers; reset wins over clear and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      tmrErr_q    <= 1'b0;
      errSticky_q <= 1'b0;
      errIdx_q    <= '0;
      errCnt_q    <= '0;
    end else begin
      out_q       <= out_d;
      tmrErr_q    <= tmrErr_d;
      errSticky_q <= errSticky_d;
      errIdx_q    <= errIdx_d;
      errCnt_q    <= errCnt_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.tmrErr    = tmrErr_q;
  assign bus.errSticky = errSticky_q;
  assign bus.errIdx    = errIdx_q;
  assign bus.errCnt    = errCnt_q;

`ifdef MAJORITY_VOTER_LANE_CNT_EN
  logic                 diffA, diffB, diffC;
  logic [CNT_WIDTH-1:0] errCntA_q, errCntA_d;
  logic [CNT_WIDTH-1:0] errCntB_q, errCntB_d;
  logic [CNT_WIDTH-1:0] errCntC_q, errCntC_d;

  // A replica is blamed whenever it disagrees with the vote in any bit;
  // several replicas can be blamed in the same cycle.
  always_comb begin
    diffA     = |(bus.inA ^ vote);
    diffB     = |(bus.inB ^ vote);
    diffC     = |(bus.inC ^ vote);
    errCntA_d = cntNext(errCntA_q, bus.clr, diffA);
    errCntB_d = cntNext(errCntB_q, bus.clr, diffB);
    errCntC_d = cntNext(errCntC_q, bus.clr, diffC);
  end

  // Per-replica counter registers, cleared by reset like the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      errCntA_q <= '0;
      errCntB_q <= '0;
      errCntC_q <= '0;
    end else begin
      errCntA_q <= errCntA_d;
      errCntB_q <= errCntB_d;
      errCntC_q <= errCntC_d;
    end
  end

  assign bus.errCntA = errCntA_q;
  assign bus.errCntB = errCntB_q;
  assign bus.errCntC = errCntC_q;
`endif

endmodule

// File: tb/tb_majority_voter_monitor.sv
// Bench for majority_voter_monitor: a wide-counter instance and a 2-bit
// counter instance share the same stimulus; a behavioural model is compared
// on every falling edge and directed vectors pin literal expectations.
module tb_majority_voter_monitor;

  localparam int W      = 8;
  localparam int CW     = 16;
  localparam int CWS    = 2;
  localparam int CMAX   = (1 << CW) - 1;
  localparam int CMAXS  = (1 << CWS) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  majority_voter_monitor_if #(.WIDTH(W), .CNT_WIDTH(CW))  bus ();
  majority_voter_monitor_if #(.WIDTH(W), .CNT_WIDTH(CWS)) busS ();

  majority_voter_monitor #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  majority_voter_monitor #(.WIDTH(W), .CNT_WIDTH(CWS)) dutSmall (
    .clk (clk),
    .rst (rst),
    .bus (busS.slave)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Model state: what every output must read after the most recent edge.
  int  mOut, mTmrErr, mSticky, mIdx, mCnt, mCntS;
  int  mCntA, mCntB, mCntC;
  bit  modelValid = 1'b0;

  // Bump a counter under the clear/saturation rules using plain integers.
  function automatic int bump(input int cur, input bit clear, input bit hit, input int maxV);
    if (clear) return hit ? 1 : 0;
    if (hit && cur < maxV) return cur + 1;
    return cur;
  endfunction

  // Model update at each rising edge from the values the DUT samples.
  always @(posedge clk) begin
    int a, b, c, v, lo, ones;
    bit any, found, hA, hB, hC;
    a = int'(bus.inA); b = int'(bus.inB); c = int'(bus.inC);
    if (rst) begin
      mOut = 0; mTmrErr = 0; mSticky = 0; mIdx = 0; mCnt = 0; mCntS = 0;
      mCntA = 0; mCntB = 0; mCntC = 0;
      modelValid = 1'b1;
    end else begin
      v = 0; any = 0; found = 0; lo = 0;
      for (int i = 0; i < W; i++) begin
        ones = ((a >> i) & 1) + ((b >> i) & 1) + ((c >> i) & 1);
        if (ones >= 2) v = v | (1 << i);
        if (ones == 1 || ones == 2) begin
          any = 1;
          if (!found) begin lo = i; found = 1; end
        end
      end
      hA = (a != v); hB = (b != v); hC = (c != v);
      mOut = v;
      mTmrErr = any;
      mCnt  = bump(mCnt,  bus.clr, any, CMAX);
      mCntS = bump(mCntS, bus.clr, any, CMAXS);
      mCntA = bump(mCntA, bus.clr, hA, CMAX);
      mCntB = bump(mCntB, bus.clr, hB, CMAX);
      mCntC = bump(mCntC, bus.clr, hC, CMAX);
      if (bus.clr) begin
        mSticky = any;
        mIdx = any ? lo : 0;
      end else if (any && !mSticky) begin
        mSticky = 1;
        mIdx = lo;
      end
    end
  end

  // One comparison: counts it and reports a miss.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("mdl.out",       64'(bus.out),       64'(mOut));
      checkOutput("mdl.tmrErr",    64'(bus.tmrErr),    64'(mTmrErr));
      checkOutput("mdl.errSticky", 64'(bus.errSticky), 64'(mSticky));
      checkOutput("mdl.errIdx",    64'(bus.errIdx),    64'(mIdx));
      checkOutput("mdl.errCnt",    64'(bus.errCnt),    64'(mCnt));
      checkOutput("mdl.errCntS",   64'(busS.errCnt),   64'(mCntS));
`ifdef MAJORITY_VOTER_LANE_CNT_EN
      checkOutput("mdl.errCntA",   64'(bus.errCntA),   64'(mCntA));
      checkOutput("mdl.errCntB",   64'(bus.errCntB),   64'(mCntB));
      checkOutput("mdl.errCntC",   64'(bus.errCntC),   64'(mCntC));
`endif
    end
  end

  // Drive one cycle of inputs to both instances and step past the edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic clrV, input logic rstV);
    bus.inA = a;  bus.inB = b;  bus.inC = c;  bus.clr = clrV;
    busS.inA = a; busS.inB = b; busS.inC = c; busS.clr = clrV;
    rst = rstV;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int satExp [5];
    logic [W-1:0] base, fa, fb;
    satExp = '{1, 2, 3, 3, 3};

    bus.inA = '1; bus.inB = '1; bus.inC = '1; bus.clr = 1'b0;
    busS.inA = '1; busS.inB = '1; busS.inC = '1; busS.clr = 1'b0;

    // Reset with all-ones replicas.
    applyStimulus(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    checkOutput("rst.out",       64'(bus.out),       64'h0);
    checkOutput("rst.tmrErr",    64'(bus.tmrErr),    64'h0);
    checkOutput("rst.errSticky", 64'(bus.errSticky), 64'h0);
    checkOutput("rst.errIdx",    64'(bus.errIdx),    64'h0);
    checkOutput("rst.errCnt",    64'(bus.errCnt),    64'h0);

    applyStimulus(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    checkOutput("rel.out",    64'(bus.out),    64'hFF);
    checkOutput("rel.tmrErr", 64'(bus.tmrErr), 64'h0);

    // Single upset on replica C, bit 3.
    applyStimulus(8'h5A, 8'h5A, 8'h52, 1'b0, 1'b0);
    checkOutput("seu.out",       64'(bus.out),       64'h5A);
    checkOutput("seu.tmrErr",    64'(bus.tmrErr),    64'h1);
    checkOutput("seu.errSticky", 64'(bus.errSticky), 64'h1);
    checkOutput("seu.errIdx",    64'(bus.errIdx),    64'd3);
    checkOutput("seu.errCnt",    64'(bus.errCnt),    64'd1);
`ifdef MAJORITY_VOTER_LANE_CNT_EN
    checkOutput("seu.errCntA", 64'(bus.errCntA), 64'd0);
    checkOutput("seu.errCntB", 64'(bus.errCntB), 64'd0);
    checkOutput("seu.errCntC", 64'(bus.errCntC), 64'd1);
`endif

    // Clear, then bit 6 followed by bit 1: first index retained.
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h40, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("b6.errIdx", 64'(bus.errIdx), 64'd6);
    applyStimulus(8'h00, 8'h02, 8'h00, 1'b0, 1'b0);
    checkOutput("b1.errIdx", 64'(bus.errIdx), 64'd6);
    checkOutput("b1.errCnt", 64'(bus.errCnt), 64'd2);
    checkOutput("b1.tmrErr", 64'(bus.tmrErr), 64'h1);

    // Clear without a mismatch.
    applyStimulus(8'h33, 8'h33, 8'h33, 1'b1, 1'b0);
    checkOutput("clr.errCnt",    64'(bus.errCnt),    64'd0);
    checkOutput("clr.errSticky", 64'(bus.errSticky), 64'h0);
    checkOutput("clr.errIdx",    64'(bus.errIdx),    64'd0);
    checkOutput("clr.out",       64'(bus.out),       64'h33);

    // Clear coinciding with a bit-2 mismatch.
    applyStimulus(8'h00, 8'h00, 8'h04, 1'b1, 1'b0);
    checkOutput("clrMis.errCnt",    64'(bus.errCnt),    64'd1);
    checkOutput("clrMis.errSticky", 64'(bus.errSticky), 64'h1);
    checkOutput("clrMis.errIdx",    64'(bus.errIdx),    64'd2);

    // Quiet cycle holds the count.
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("hold.errCnt", 64'(bus.errCnt), 64'd1);
    checkOutput("hold.tmrErr", 64'(bus.tmrErr), 64'h0);

    // Cross-replica upset after a clear: A bit 0, B bit 4.
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h01, 8'h10, 8'h00, 1'b0, 1'b0);
    checkOutput("cross.out",    64'(bus.out),    64'h00);
    checkOutput("cross.errCnt", 64'(bus.errCnt), 64'd1);
    checkOutput("cross.errIdx", 64'(bus.errIdx), 64'd0);
`ifdef MAJORITY_VOTER_LANE_CNT_EN
    checkOutput("cross.errCntA", 64'(bus.errCntA), 64'd1);
    checkOutput("cross.errCntB", 64'(bus.errCntB), 64'd1);
    checkOutput("cross.errCntC", 64'(bus.errCntC), 64'd0);
`endif

    // Saturation of the 2-bit counter over five mismatch cycles.
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h80, 8'h00, 8'h00, 1'b0, 1'b0);
      checkOutput("sat.errCntS", 64'(busS.errCnt), 64'(satExp[i]));
      checkOutput("sat.errCnt",  64'(bus.errCnt),  64'(i + 1));
    end

    // Reset mid-operation during a mismatch, then recovery.
    applyStimulus(8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1);
    checkOutput("midRst.errCnt",    64'(bus.errCnt),    64'd0);
    checkOutput("midRst.errSticky", 64'(bus.errSticky), 64'h0);
    checkOutput("midRst.out",       64'(bus.out),       64'h0);
    applyStimulus(8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0);
    checkOutput("post.out",    64'(bus.out),    64'hFF);
    checkOutput("post.errIdx", 64'(bus.errIdx), 64'd0);
    checkOutput("post.errCnt", 64'(bus.errCnt), 64'd1);

    // Mixed traffic checked only against the model.
    for (int i = 0; i < 60; i++) begin
      base = W'($urandom);
      fa = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      fb = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      applyStimulus(base ^ fa, base, base ^ fb, ($urandom_range(0, 7) == 0), 1'b0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/majority_voter_monitor.md
# majority_voter_monitor

Parametrised, registered triple-modular-redundancy voter with error bookkeeping. It votes three WIDTH-bit replicas bitwise and registers the result. It flags any disagreement, keeps a saturating count of mismatch cycles, and captures the bit index of the first mismatch since the last clear. It sits at the boundary of triplicated periphery registers, where the slow-control readout needs to see single-event upsets rather than have them masked silently.

## Interface
Parameters:
- WIDTH, 8, number of voted bits (≥1)
- CNT_WIDTH, 16, width of each mismatch counter (≥2)

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- inA  input  WIDTH  replica A
- inB  input  WIDTH  replica B
- inC  input  WIDTH  replica C
- clr  input  1  single-cycle request to clear counters, sticky flag and captured index
- out  output  WIDTH  registered majority value
- tmrErr  output  1  registered; high for one cycle per cycle in which any bit mismatched
- errSticky  output  1  set on first mismatch, held until clr or rst
- errIdx  output  IDX_W  lowest mismatching bit index of the first mismatch since clear; IDX_W = max(1, $clog2(WIDTH))
- errCnt  output  CNT_WIDTH  saturating count of mismatch cycles (combined counter)
- errCntA, errCntB, errCntC  output  CNT_WIDTH each  per-replica counters (present only with the macro, see Configuration)

## Operation
- Per bit i: vote[i] = (A&B)|(B&C)|(A&C); mis[i] = ~(A==B && B==C).
- anyMis = |mis. lowIdx = the lowest i with mis[i]=1.
- Every edge, with rst=0: out <= vote; tmrErr <= anyMis.
- Counter: if clr, errCnt <= (anyMis ? 1 : 0). Else, if anyMis and errCnt is not all-ones, errCnt <= errCnt+1. Otherwise hold. Saturates at 2^CNT_WIDTH−1 and never wraps.
- Sticky/index: if clr, errSticky <= anyMis and errIdx <= (anyMis ? lowIdx : 0). Else, if anyMis and !errSticky, errSticky <= 1 and errIdx <= lowIdx. Later mismatches do not change errIdx.
- Simultaneous clr and mismatch: the clear takes effect and the current mismatch is counted. The result is count=1, sticky=1, and the index of the current cycle.
- A mismatch with all replicas pairwise different across bits (e.g. A differs on bit 0, B differs on bit 3) is still a single mismatch cycle and increments errCnt by 1.
- Reset has priority over clr and over data.

## Timing
- Reset values: out=0, tmrErr=0, errSticky=0, errIdx=0, errCnt=0, errCntA/B/C=0.
- Latency: inputs to out, tmrErr, counters and sticky/index is 1 cycle. All outputs update on the same edge.
- clr has no handshake. It is sampled each cycle, and holding it high keeps the counters at 0 or 1.
- Reset asserted mid-operation clears all state on the next edge. The first post-reset output reflects the inputs sampled on the first edge with rst=0.

## Configuration
- MAJORITY_VOTER_LANE_CNT_EN defined:
  - Adds errCntA/B/C.
  - errCntX increments, with the same saturation and clr rules as errCnt, when replica X differs from vote in any bit.
  - Two or three per-replica counters may increment in the same cycle.
- Not defined: the per-replica ports and their logic are absent, and only errCnt exists.

## Structure
- Shared package tmr_pkg:
  - default CNT_WIDTH constant
  - an index-width function max(1,$clog2(w))
  - a saturating-increment function reused by all counters
- Sub-module tmr_vote_bit:
  - one-bit voter returning vote and mismatch
  - instantiated WIDTH times in a generate loop
- The priority encoder for lowIdx and the counters stay in the top module.

## Test plan
- Reset: assert rst with inA=inB=inC=8'hFF → all outputs 0. One cycle after release: out=8'hFF, tmrErr=0.
- Single upset: inA=8'h5A, inB=8'h5A, inC=8'h52 → out=8'h5A, tmrErr=1, errSticky=1, errIdx=3, errCnt=1. With the macro: errCntC=1, errCntA=errCntB=0.
- First-index retention: mismatch on bit 6, then on bit 1 → errIdx stays 6 and errCnt=2. Then pulse clr with no mismatch → errCnt=0, errSticky=0, errIdx=0.
- clr coinciding with a bit-2 mismatch → errCnt=1, errSticky=1, errIdx=2.
- Saturation: CNT_WIDTH=2 with 5 consecutive mismatch cycles → errCnt sequence 1,2,3,3,3.
- Cross-replica: A flips bit 0 and B flips bit 4 in the same cycle → errCnt increments by 1 and errIdx=0. With the macro: errCntA and errCntB each increment by 1.
